// File: rtl/popcount_enumerator_if.sv
// Vector stream from popcount_enumerator to its consumer.
// master drives vec/vec_vld, slave drives vec_rdy.
interface popcount_enumerator_if #(
  parameter int W = 7
) ();
  logic [W-1:0] vec;
  logic         vec_vld;
  logic         vec_rdy;

  modport master (
    output vec,
    output vec_vld,
    input  vec_rdy
  );

  modport slave (
    input  vec,
    input  vec_vld,
    output vec_rdy
  );
endinterface

// File: rtl/popcount_enumerator.sv
// Emits every W-bit vector of popcount k in ascending order.
// Ports: clk, rst (sync, active high), start, k, abort, busy, done,
// bus (master: vec, vec_vld, vec_rdy), tally when
// POPCOUNT_ENUM_TALLY_EN is defined (handshakes this enumeration).
module popcount_enumerator #(
  parameter  int W  = 7,
  localparam int KW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic          abort,
  output logic          busy,
  output logic          done,
`ifdef POPCOUNT_ENUM_TALLY_EN
  output logic [W-2:0]  tally,
`endif
  popcount_enumerator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  vec_q, vec_d;
  logic          vld_q, vld_d;
  logic [KW-1:0] pc;
  logic          match;
  logic          last;
  logic          hs;

  always_comb begin
    pc = '0;
    for (int i = 0; i < W; i++) begin
      pc = pc + KW'(cnt_q[i]);
    end
  end

  assign match = (pc == k_q);
  assign last  = (cnt_q == '1);
  assign hs    = (state_q == HOLD) && vld_q && bus.vec_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    vec_d   = vec_q;
    vld_d   = vld_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = k;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          vec_d   = cnt_q;
          vld_d   = 1'b1;
          state_d = HOLD;
        end else if (last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (hs) begin
          vld_d = 1'b0;
          if (last) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort overrides everything, including a same-cycle handshake
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      vld_d   = 1'b0;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      vec_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      vld_q   <= vld_d;
    end
  end

`ifdef POPCOUNT_ENUM_TALLY_EN
  logic [W-2:0] tally_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tally_q <= '0;
    end else if (state_q == IDLE && start) begin
      tally_q <= '0;
    end else if (hs && !abort) begin
      tally_q <= tally_q + 1'b1;
    end
  end

  assign tally = tally_q;
`endif

  assign bus.vec     = vec_q;
  assign bus.vec_vld = vld_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_popcount_enumerator.sv
// Bench for popcount_enumerator: reference list of all W-bit values
// with the target popcount, compared against the emitted stream.
module tb_popcount_enumerator;
  localparam int W  = 7;
  localparam int KW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] k;
  logic          abort;
  logic          busy;
  logic          done;
`ifdef POPCOUNT_ENUM_TALLY_EN
  logic [W-2:0]  tally;
`endif
  int            checks;
  int            errors;

  popcount_enumerator_if #(.W(W)) bus ();

  popcount_enumerator #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .k     (k),
    .abort (abort),
    .busy  (busy),
    .done  (done),
`ifdef POPCOUNT_ENUM_TALLY_EN
    .tally (tally),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One enumeration. abort_at/rst_at > 0 cut it short once that many
  // vectors were accepted and the next one is on offer.
  task automatic run(input int kk, input bit rnd,
                     input int abort_at, input int rst_at);
    logic [W-1:0] exq[$];
    logic [W-1:0] held;
    int got;
    int dones;
    int n_exp;
    bit fin;
    bit stall;
    bit cut;
    bit r;
    got = 0;
    dones = 0;
    fin = 0;
    stall = 0;
    cut = 0;
    held = '0;
    for (int v = 0; v < (1 << W); v++) begin
      if ($countones(v) == kk) exq.push_back(W'(v));
    end
    n_exp = abort_at > 0 ? abort_at :
            (rst_at > 0 ? rst_at : exq.size());
    start = 1'b1;
    k = KW'(kk);
    bus.vec_rdy = 1'b0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      if (cut) begin
        chk("cut_state", {busy, done, bus.vec_vld}, 3'b000);
        rst = 1'b0;
        fin = 1;
      end else begin
        if (c == 0) chk("busy_start", busy, 1);
        if (stall) begin
          chk("hold_stable", {bus.vec_vld, bus.vec}, {1'b1, held});
        end
        if (done) dones++;
        if (!busy) begin
          fin = 1;
        end else begin
          r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
          if (bus.vec_vld && rst_at > 0 && got == rst_at) begin
            r = 1'b0;
            rst = 1'b1;
            cut = 1;
          end else if (bus.vec_vld && r && abort_at > 0 &&
                       got == abort_at) begin
            abort = 1'b1;
            start = 1'b1;
            k = KW'(kk);
            cut = 1;
          end else if (bus.vec_vld && r) begin
            if (got < exq.size()) chk("vec", bus.vec, exq[got]);
            else chk("extra_vec", got, exq.size());
            got++;
          end
          bus.vec_rdy = r;
          stall = bus.vec_vld && !r;
          held = bus.vec;
        end
      end
    end
    bus.vec_rdy = 1'b0;
    chk("finished", fin, 1);
    chk("count", got, n_exp);
    chk("dones", dones, (abort_at > 0 || rst_at > 0) ? 0 : 1);
`ifdef POPCOUNT_ENUM_TALLY_EN
    chk("tally", tally, rst_at > 0 ? 0 : n_exp);
`endif
    @(posedge clk);
    #1;
    chk("idle_after", {busy, done, bus.vec_vld}, 3'b000);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    k = '0;
    abort = 1'b0;
    bus.vec_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle", {bus.vec_vld, busy, done, bus.vec}, '0);
      @(posedge clk);
      #1;
    end
`ifdef POPCOUNT_ENUM_TALLY_EN
    chk("reset_tally", tally, 0);
`endif
    run(3, 0, 0, 0);
    run(0, 0, 0, 0);
    run(W, 0, 0, 0);
    run(2, 1, 0, 0);
    run(4, 0, 5, 0);
    run(4, 0, 0, 0);
    run(5, 1, 0, 3);
    run(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run(int'($urandom_range(0, W)), 1, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
